// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and branch-control bundle for fetch_unit.
// slave  (fetch_unit): takes start, imem_data, branchType, threewireOffset,
//                      sixwireOffset, flag, returnAddr and halt; drives
//                      imem_addr, OPCODE, A, B, programCounter, instr_valid,
//                      done and cycle_count.
// master (controller/bench): the mirror image.
interface fetch_unit_if #(parameter int CNT_W = 16);
    logic             start;
    logic [8:0]       imem_data;
    logic [6:0]       imem_addr;
    logic [2:0]       OPCODE;
    logic [2:0]       A;
    logic [2:0]       B;
    logic [6:0]       programCounter;
    logic [1:0]       branchType;
    logic [2:0]       threewireOffset;
    logic [5:0]       sixwireOffset;
    logic             flag;
    logic [6:0]       returnAddr;
    logic             halt;
    logic             instr_valid;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    modport slave (
        input  start, imem_data, branchType, threewireOffset, sixwireOffset,
               flag, returnAddr, halt,
        output imem_addr, OPCODE, A, B, programCounter, instr_valid, done,
               cycle_count
    );

    modport master (
        output start, imem_data, branchType, threewireOffset, sixwireOffset,
               flag, returnAddr, halt,
        input  imem_addr, OPCODE, A, B, programCounter, instr_valid, done,
               cycle_count
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/RUN/HALTED program-counter sequencer with branch handling.
// Ports: clk, reset_n (async active-low), bus (fetch_unit_if.slave).
// Optional macro FETCH_CYCLE_COUNT_EN adds a saturating count of RUN edges on
// bus.cycle_count; without it cycle_count is tied to 0.
module fetch_unit #(
    parameter logic [6:0] START_ADDR = 7'd0,
    parameter int         CNT_W      = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    fetch_unit_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t     st, nst;
    logic [6:0] pc, npc;
    logic       run, go;

    assign run = (st == RUN);
    assign go  = bus.start && (st != RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= IDLE;
            pc <= 7'd0;
        end else begin
            st <= nst;
            pc <= npc;
        end
    end

    always_comb begin
        nst = st;
        npc = pc;
        case (st)
            IDLE, HALTED: begin
                if (bus.start) begin
                    nst = RUN;
                    npc = START_ADDR;
                end
            end
            RUN: begin
                // halt wins over any branch; PC stays on the HALT instruction
                if (bus.halt) nst = HALTED;
                else begin
                    case (bus.branchType)
                        2'b00: npc = pc + 7'd1;
                        2'b01: npc = bus.returnAddr;
                        2'b10: npc = bus.flag ? pc + 7'd1 : pc - {4'd0, bus.threewireOffset};
                        default: npc = bus.flag ? pc + {bus.sixwireOffset[5], bus.sixwireOffset} : pc + 7'd1;
                    endcase
                end
            end
            default: nst = IDLE;
        endcase
    end

    assign bus.imem_addr      = pc;
    assign bus.programCounter = pc;
    assign bus.OPCODE         = run ? bus.imem_data[8:6] : 3'd0;
    assign bus.A              = run ? bus.imem_data[5:3] : 3'd0;
    assign bus.B              = run ? bus.imem_data[2:0] : 3'd0;
    assign bus.instr_valid    = run;
    assign bus.done           = (st == HALTED);

`ifdef FETCH_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (go) cnt <= '0;
        else if (run) cnt <= (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    assign bus.cycle_count = cnt;
`else
    logic unused_go;
    assign unused_go       = go;
    assign bus.cycle_count = {CNT_W{1'b0}};
`endif
endmodule
